// File: rtl/m_dmem_arbiter.sv
// Two-master (CPU/DMA) arbiter and sequencer for the byte-enabled data-memory port.
// Build option: DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority instead of round-robin.

module m_dmem_be_check (
  input  logic [1:0] lowAddr,
  input  logic [3:0] byteen,
  output logic       ok
);
  // Legal pattern and its lowest enabled lane must match the address offset.
  always_comb begin
    ok = 1'b0;
    case (byteen)
      4'b0000:                   ok = 1'b1;
      4'b0001, 4'b0011, 4'b1111: ok = (lowAddr == 2'b00);
      4'b0010:                   ok = (lowAddr == 2'b01);
      4'b0100, 4'b1100:          ok = (lowAddr == 2'b10);
      4'b1000:                   ok = (lowAddr == 2'b11);
      default:                   ok = 1'b0;
    endcase
  end
endmodule

module m_dmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int NUM_MST = 2;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } dmemReqT;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} stateT;

  stateT                   state, stateNxt;
  dmemReqT [NUM_MST-1:0]   mReq;
  logic    [NUM_MST-1:0]   mVld, mOk;
  logic                    anyReq, grantDma, timeoutHit;
  logic                    owner;  // 0 = CPU, 1 = DMA
  logic    [29:0]          addrQ;
  logic    [31:0]          wdataQ, rdataQ;
  logic    [3:0]           beQ;
  logic                    errQ;
  logic    [CNT_W-1:0]     cnt;

  assign mReq[0] = '{addr: cpu_addr, wdata: cpu_wdata, byteen: cpu_byteen};
  assign mReq[1] = '{addr: dma_addr, wdata: dma_wdata, byteen: dma_byteen};
  assign mVld    = {dma_req, cpu_req};
  assign anyReq  = |mVld;

  for (genvar g = 0; g < NUM_MST; g++) begin : gChk
    m_dmem_be_check uChk (
      .lowAddr (mReq[g].addr[1:0]),
      .byteen  (mReq[g].byteen),
      .ok      (mOk[g])
    );
  end

`ifdef DMEM_ARB_CPU_PRIO_EN
  assign grantDma = mVld[1] & ~mVld[0];
`else
  logic rrCpuNext;
  assign grantDma = mVld[1] & (~mVld[0] | ~rrCpuNext);

  // Point at the master that did not own the transaction just finished.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)            rrCpuNext <= 1'b1;
    else if (state == RESP)  rrCpuNext <= owner;
`endif

  assign timeoutHit = (cnt == LIMIT);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= stateNxt;

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (anyReq) stateNxt = mOk[grantDma] ? ISSUE : RESP;
      ISSUE:   if (mem_ack || timeoutHit) stateNxt = RESP;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner  <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      beQ    <= '0;
      rdataQ <= '0;
      errQ   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (anyReq) begin
          owner  <= grantDma;
          addrQ  <= mReq[grantDma].addr[31:2];
          wdataQ <= mReq[grantDma].wdata;
          beQ    <= mReq[grantDma].byteen;
          errQ   <= ~mOk[grantDma];
          rdataQ <= '0;
          cnt    <= '0;
        end
        ISSUE: begin
          // Ack takes precedence over a timeout landing in the same cycle.
          if (mem_ack) begin
            rdataQ <= (beQ == 4'b0000) ? mem_rdata : 32'h0;
            errQ   <= 1'b0;
          end else if (timeoutHit) begin
            rdataQ <= '0;
            errQ   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    busy       = 1'b0;
    mem_addr   = {addrQ, 2'b00};
    mem_wdata  = wdataQ;
    mem_byteen = beQ;
    cpu_done   = 1'b0;
    cpu_rdata  = '0;
    cpu_err    = 1'b0;
    dma_done   = 1'b0;
    dma_rdata  = '0;
    dma_err    = 1'b0;
    case (state)
      ISSUE: begin
        mem_req = 1'b1;
        busy    = 1'b1;
      end
      RESP: begin
        busy = 1'b1;
        if (owner) begin
          dma_done  = 1'b1;
          dma_rdata = rdataQ;
          dma_err   = errQ;
        end else begin
          cpu_done  = 1'b1;
          cpu_rdata = rdataQ;
          cpu_err   = errQ;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_m_dmem_arbiter.sv
// Directed bench for m_dmem_arbiter: scoreboard of expected responses, checked with immediate assertions.
module tb_m_dmem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, dma_req, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [3:0]  cpu_byteen, dma_byteen;
  logic        cpu_done, cpu_err, dma_done, dma_err, mem_req, busy;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;

  int total = 0;
  int bad   = 0;
  bit tbCpuNext = 1'b1;

  typedef struct {
    bit          isDma;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          err;
    int          memCyc;
  } expT;
  expT sb[$];

  m_dmem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_byteen(dma_byteen),
    .dma_done(dma_done), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit tbLegal(input logic [31:0] a, input logic [3:0] be);
    int lo;
    if (be == 4'b0000) return 1'b1;
    if (!(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) return 1'b0;
    lo = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
    return int'(a[1:0]) == lo;
  endfunction

  function automatic expT mkExp(input bit isDma, input logic [31:0] a, input logic [31:0] w,
                                input logic [3:0] be, input int ackCyc, input logic [31:0] rd);
    expT e;
    e.isDma = isDma; e.addr = a; e.wdata = w; e.be = be;
    if (!tbLegal(a, be)) begin
      e.err = 1'b1; e.rdata = 32'h0; e.memCyc = 0;
    end else if (ackCyc >= 1 && ackCyc <= TO) begin
      e.err = 1'b0; e.rdata = (be == 4'b0000) ? rd : 32'h0; e.memCyc = ackCyc;
    end else begin
      e.err = 1'b1; e.rdata = 32'h0; e.memCyc = TO;
    end
    return e;
  endfunction

  // Drive one or both masters; each memory access is acked in its ackCyc-th ISSUE cycle (0 = never).
  task automatic run(input bit cEn, input logic [31:0] cA, input logic [31:0] cW, input logic [3:0] cB,
                     input bit dEn, input logic [31:0] dA, input logic [31:0] dW, input logic [3:0] dB,
                     input int ackCyc, input logic [31:0] rd);
    expT ec, ed, e;
    bit  cpuFirst;
    int  cyc, memCnt, base;
    ec = mkExp(1'b0, cA, cW, cB, ackCyc, rd);
    ed = mkExp(1'b1, dA, dW, dB, ackCyc, rd);
    if (cEn && dEn) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      cpuFirst = 1'b1;
`else
      cpuFirst = tbCpuNext;
`endif
      if (cpuFirst) begin sb.push_back(ec); sb.push_back(ed); end
      else          begin sb.push_back(ed); sb.push_back(ec); end
    end else if (cEn) sb.push_back(ec);
    else if (dEn)     sb.push_back(ed);
    cpu_req = cEn; cpu_addr = cA; cpu_wdata = cW; cpu_byteen = cB;
    dma_req = dEn; dma_addr = dA; dma_wdata = dW; dma_byteen = dB;
    cyc = 0; memCnt = 0; base = 0;
    while (sb.size() > 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      mem_rdata = 32'h5A5A_0F0F;
      if (mem_req) begin
        memCnt++;
        e = sb[0];
        chk("mem_addr", mem_addr, {e.addr[31:2], 2'b00});
        chk("mem_byteen", {28'h0, mem_byteen}, {28'h0, e.be});
        chk("mem_wdata", mem_wdata, e.wdata);
        if (memCnt == ackCyc) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
      end
      if (cpu_done || dma_done) begin
        e = sb.pop_front();
        chk("done_onehot", {31'h0, cpu_done & dma_done}, 32'h0);
        chk("owner", {31'h0, dma_done}, {31'h0, e.isDma});
        chk("rdata", dma_done ? dma_rdata : cpu_rdata, e.rdata);
        chk("err", {31'h0, dma_done ? dma_err : cpu_err}, {31'h0, e.err});
        chk("other_rdata", dma_done ? cpu_rdata : dma_rdata, 32'h0);
        chk("other_err", {31'h0, dma_done ? cpu_err : dma_err}, 32'h0);
        chk("mem_cycles", memCnt, e.memCyc);
        chk("latency", cyc, base + e.memCyc + 1);
        if (dma_done) dma_req = 1'b0; else cpu_req = 1'b0;
        tbCpuNext = dma_done;
        memCnt = 0;
        base = cyc + 1;
      end
    end
    if (sb.size() != 0) begin
      chk("txn_timeout", sb.size(), 0);
      sb.delete();
    end
    cpu_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_after", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_req = 0; cpu_addr = 0; cpu_wdata = 0; cpu_byteen = 0;
    dma_req = 0; dma_addr = 0; dma_wdata = 0; dma_byteen = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_done", {30'h0, cpu_done, dma_done}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // First tie after reset, then a CPU-only write, then a second tie (DMA next under round-robin)
    run(1, 32'h0000_0010, 32'h0, 4'b0000, 1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 1, 32'hCAFE_0001);
    run(1, 32'h0000_0104, 32'h0000_00AB, 4'b0001, 0, 32'h0, 32'h0, 4'b0000, 3, 32'h1234_5678);
    run(1, 32'h0000_0032, 32'h00AA_0000, 4'b0100, 1, 32'h0000_0040, 32'h0, 4'b0000, 2, 32'h0BAD_F00D);
    // DMA read
    run(0, 32'h0, 32'h0, 4'b0000, 1, 32'h0000_0200, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF);
    // Illegal pattern and misaligned half-word
    run(1, 32'h0000_0008, 32'hFFFF_FFFF, 4'b0101, 0, 32'h0, 32'h0, 4'b0000, 1, 32'h0);
    run(1, 32'h0000_0000, 32'hFFFF_0000, 4'b1100, 0, 32'h0, 32'h0, 4'b0000, 1, 32'h0);
    run(0, 32'h0, 32'h0, 4'b0000, 1, 32'h0000_0301, 32'h0000_5500, 4'b0010, 2, 32'h0);
    // Timeout with no ack, then ack exactly in the last allowed cycle
    run(1, 32'h0000_0400, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 4'b0000, 0, 32'h0);
    run(1, 32'h0000_0404, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 4'b0000, TO, 32'h7777_8888);

    // Stray ack while idle is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_busy", {31'h0, busy}, 32'h0);
    chk("stray_ack_done", {30'h0, cpu_done, dma_done}, 32'h0);

    // Leave the pointer at DMA, then reset in the middle of ISSUE
    run(1, 32'h0000_0500, 32'h0000_0001, 4'b0001, 0, 32'h0, 32'h0, 4'b0000, 1, 32'h0);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0600; cpu_byteen = 4'b0000;
    repeat (2) @(negedge clk);
    chk("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_mem_req", {31'h0, mem_req}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tbCpuNext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", {30'h0, cpu_done, dma_done}, 32'h0);
    end
    run(1, 32'h0000_0700, 32'h0, 4'b0000, 1, 32'h0000_0704, 32'h0, 4'b0000, 1, 32'h3141_5926);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
